// File: rtl/operand_fetch.sv
// ---------------------------------------------------------------------------
// operand_fetch
//   Two-stage operand fetch between decode and execute.
//   S1 holds an accepted instruction while its synchronous register-file read
//   completes. S2 holds the resolved operand bundle that drives the outputs.
//   Writeback hazards are resolved in two places:
//     - S1: the register file returns old data when a read and a write hit the
//       same edge. A one-deep bypass latch captures that write.
//     - S2: while the bundle is stalled, matching writebacks patch it in place.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       upstream handshake
//   in_pc, in_rs1, in_rs2     incoming PC and source register addresses
//   rf_r_addr1/2              register file read addresses
//   rf_read_reg1/2            register file read data (1-cycle latency)
//   wb_we, wb_addr, wb_data   writeback port shared with the register file
//   out_valid / out_ready     downstream handshake
//   out_pc, out_rs1_val,
//   out_rs2_val               registered PC and resolved operands
// ---------------------------------------------------------------------------
module operand_fetch #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_pc,
   input  logic [ADDR_WIDTH-1:0] in_rs1,
   input  logic [ADDR_WIDTH-1:0] in_rs2,
   output logic [ADDR_WIDTH-1:0] rf_r_addr1,
   output logic [ADDR_WIDTH-1:0] rf_r_addr2,
   input  logic [WIDTH-1:0]      rf_read_reg1,
   input  logic [WIDTH-1:0]      rf_read_reg2,
   input  logic                  wb_we,
   input  logic [ADDR_WIDTH-1:0] wb_addr,
   input  logic [WIDTH-1:0]      wb_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_pc,
   output logic [WIDTH-1:0]      out_rs1_val,
   output logic [WIDTH-1:0]      out_rs2_val
);

   // S1 state
   logic                  r_s1_valid;
   logic [WIDTH-1:0]      r_s1_pc;
   logic [ADDR_WIDTH-1:0] r_s1_rs1;
   logic [ADDR_WIDTH-1:0] r_s1_rs2;
   logic                  r_byp1_flag;
   logic                  r_byp2_flag;
   logic [WIDTH-1:0]      r_byp1_data;
   logic [WIDTH-1:0]      r_byp2_data;

   // S2 state
   logic                  r_s2_valid;
   logic [WIDTH-1:0]      r_out_pc;
   logic [WIDTH-1:0]      r_out_rs1_val;
   logic [WIDTH-1:0]      r_out_rs2_val;
   logic [ADDR_WIDTH-1:0] r_s2_rs1;
   logic [ADDR_WIDTH-1:0] r_s2_rs2;

   logic                  w_s1_adv;
   logic                  w_in_hs;
   logic                  w_s1_load_s2;
   logic                  w_s2_hold;
   logic                  w_s1_stall;
   logic [WIDTH-1:0]      w_s1_op1;
   logic [WIDTH-1:0]      w_s1_op2;
   logic                  w_patch1;
   logic                  w_patch2;

   assign w_s1_adv     = !r_s2_valid || out_ready;
   assign in_ready     = !r_s1_valid || w_s1_adv;
   assign w_in_hs      = in_valid && in_ready;
   assign w_s1_load_s2 = r_s1_valid && w_s1_adv;
   assign w_s2_hold    = r_s2_valid && !out_ready;
   assign w_s1_stall   = r_s1_valid && !w_s1_adv;

   // A stalled S1 re-reads its own registers so it keeps tracking writebacks.
   assign rf_r_addr1 = w_s1_stall ? r_s1_rs1 : in_rs1;
   assign rf_r_addr2 = w_s1_stall ? r_s1_rs2 : in_rs2;

   assign w_s1_op1 = (r_s1_rs1 == '0) ? '0 :
                     r_byp1_flag      ? r_byp1_data : rf_read_reg1;
   assign w_s1_op2 = (r_s1_rs2 == '0) ? '0 :
                     r_byp2_flag      ? r_byp2_data : rf_read_reg2;

   assign w_patch1 = w_s2_hold && wb_we && (wb_addr == r_s2_rs1) && (r_s2_rs1 != '0);
   assign w_patch2 = w_s2_hold && wb_we && (wb_addr == r_s2_rs2) && (r_s2_rs2 != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid    <= 1'b0;
         r_byp1_flag   <= 1'b0;
         r_byp2_flag   <= 1'b0;
         r_s2_valid    <= 1'b0;
         r_out_pc      <= '0;
         r_out_rs1_val <= '0;
         r_out_rs2_val <= '0;
      end else begin
         r_byp1_flag <= wb_we && (wb_addr == rf_r_addr1);
         r_byp2_flag <= wb_we && (wb_addr == rf_r_addr2);

         if (w_in_hs) begin
            r_s1_valid <= 1'b1;
         end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
         end

         if (w_s1_adv) begin
            r_s2_valid <= r_s1_valid;
         end

         if (w_s1_load_s2) begin
            r_out_pc      <= r_s1_pc;
            r_out_rs1_val <= w_s1_op1;
            r_out_rs2_val <= w_s1_op2;
         end else begin
            if (w_patch1) begin
               r_out_rs1_val <= wb_data;
            end
            if (w_patch2) begin
               r_out_rs2_val <= wb_data;
            end
         end
      end
   end

   // Payload registers; their contents are only meaningful under the valids.
   always_ff @(posedge clk) begin
      r_byp1_data <= wb_data;
      r_byp2_data <= wb_data;
      if (w_in_hs) begin
         r_s1_pc  <= in_pc;
         r_s1_rs1 <= in_rs1;
         r_s1_rs2 <= in_rs2;
      end
      if (w_s1_load_s2) begin
         r_s2_rs1 <= r_s1_rs1;
         r_s2_rs2 <= r_s1_rs2;
      end
   end

   assign out_valid   = r_s2_valid;
   assign out_pc      = r_out_pc;
   assign out_rs1_val = r_out_rs1_val;
   assign out_rs2_val = r_out_rs2_val;

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;
   localparam int WIDTH = 32;
   localparam int AW    = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_pc;
   logic [AW-1:0]    in_rs1;
   logic [AW-1:0]    in_rs2;
   logic [AW-1:0]    rf_r_addr1;
   logic [AW-1:0]    rf_r_addr2;
   logic [WIDTH-1:0] rf_read_reg1;
   logic [WIDTH-1:0] rf_read_reg2;
   logic             wb_we;
   logic [AW-1:0]    wb_addr;
   logic [WIDTH-1:0] wb_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_pc;
   logic [WIDTH-1:0] out_rs1_val;
   logic [WIDTH-1:0] out_rs2_val;

   operand_fetch #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
      .in_rs1(in_rs1), .in_rs2(in_rs2),
      .rf_r_addr1(rf_r_addr1), .rf_r_addr2(rf_r_addr2),
      .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   bit check_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Register file: synchronous read, old data on same-edge write, no reset.
   logic [WIDTH-1:0] rf_mem [0:31];
   always @(posedge clk) begin
      rf_read_reg1 <= rf_mem[rf_r_addr1];
      rf_read_reg2 <= rf_mem[rf_r_addr2];
      if (wb_we) rf_mem[wb_addr] <= wb_data;
   end

   // Reference model: architectural register values plus two slots.
   // An instruction in the first slot always sees the current architectural
   // value; once it moves to the output slot it is a snapshot that is only
   // patched by writes landing while the bundle is held.
   logic [31:0] m_regs [0:31];
   bit          m_s1_v = 1'b0;
   bit          m_s2_v = 1'b0;
   logic [31:0] m_s1_pc;
   logic [4:0]  m_s1_rs1, m_s1_rs2, m_s2_rs1, m_s2_rs2;
   logic [31:0] m_out_pc = '0, m_out1 = '0, m_out2 = '0;
   logic [31:0] sb_q [$];
   logic [31:0] emit_q [$];

   function automatic logic [31:0] arch(input logic [4:0] a);
      return (a == 5'd0) ? 32'd0 : m_regs[a];
   endfunction

   always @(posedge clk) begin : model
      bit adv, rdy;
      logic [31:0] v1, v2;
      adv = !m_s2_v || out_ready;
      rdy = !m_s1_v || adv;
      v1  = arch(m_s1_rs1);
      v2  = arch(m_s1_rs2);
      if (rst) begin
         m_s1_v = 1'b0; m_s2_v = 1'b0;
         m_out_pc = '0; m_out1 = '0; m_out2 = '0;
         sb_q.delete();
      end else begin
         if (adv) begin
            if (m_s1_v) begin
               m_s2_v = 1'b1; m_out_pc = m_s1_pc; m_out1 = v1; m_out2 = v2;
               m_s2_rs1 = m_s1_rs1; m_s2_rs2 = m_s1_rs2;
            end else begin
               m_s2_v = 1'b0;
            end
         end else if (wb_we && wb_addr != 5'd0) begin
            if (wb_addr == m_s2_rs1) m_out1 = wb_data;
            if (wb_addr == m_s2_rs2) m_out2 = wb_data;
         end
         if (in_valid && rdy) begin
            m_s1_v = 1'b1; m_s1_pc = in_pc; m_s1_rs1 = in_rs1; m_s1_rs2 = in_rs2;
            sb_q.push_back(in_pc);
         end else if (adv) begin
            m_s1_v = 1'b0;
         end
      end
      if (wb_we) m_regs[wb_addr] = wb_data;
   end

   always @(negedge clk) begin
      if (check_en) begin
         check("in_ready", {31'd0, in_ready}, {31'd0, (!m_s1_v || !m_s2_v || out_ready)});
         check("out_valid", {31'd0, out_valid}, {31'd0, m_s2_v});
         check("out_pc", out_pc, m_out_pc);
         check("out_rs1_val", out_rs1_val, m_out1);
         check("out_rs2_val", out_rs2_val, m_out2);
         if (out_valid && out_ready && !rst) begin
            if (sb_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL order: bundle pc 0x%0h emitted, none outstanding", out_pc);
            end else begin
               check("order", out_pc, sb_q.pop_front());
            end
            emit_q.push_back(out_pc);
         end
      end
   end

   task automatic drive(input bit v, input logic [31:0] pc, input logic [4:0] r1,
                        input logic [4:0] r2, input bit we, input logic [4:0] wa,
                        input logic [31:0] wd, input bit ordy, output bit acc);
      in_valid = v; in_pc = pc; in_rs1 = r1; in_rs2 = r2;
      wb_we = we; wb_addr = wa; wb_data = wd; out_ready = ordy;
      #1;
      acc = v && in_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input bit ordy);
      bit a;
      drive(1'b0, '0, '0, '0, 1'b0, '0, '0, ordy, a);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      int n;
      logic [31:0] pc;
      rst = 1'b1; in_valid = 0; in_pc = 0; in_rs1 = 0; in_rs2 = 0;
      wb_we = 0; wb_addr = 0; wb_data = 0; out_ready = 0;
      @(posedge clk); #1;
      check_en = 1'b1;
      for (int a = 0; a < 32; a++)
         drive(1'b0, '0, '0, '0, 1'b1, a[4:0], $urandom, 1'b0, acc);
      idle(1'b0);
      check("reset out_valid", {31'd0, out_valid}, 32'd0);
      check("reset in_ready", {31'd0, in_ready}, 32'd1);
      check("reset out_pc", out_pc, 32'd0);
      rst = 1'b0;

      // Basic fetch
      drive(1'b0, '0, '0, '0, 1'b1, 5'd5, 32'h11, 1'b1, acc);
      drive(1'b0, '0, '0, '0, 1'b1, 5'd6, 32'h22, 1'b1, acc);
      drive(1'b1, 32'h100, 5'd5, 5'd6, 1'b0, '0, '0, 1'b1, acc);
      check("basic accept", {31'd0, acc}, 32'd1);
      idle(1'b1);
      check("basic valid", {31'd0, out_valid}, 32'd1);
      check("basic pc", out_pc, 32'h100);
      check("basic rs1", out_rs1_val, 32'h11);
      check("basic rs2", out_rs2_val, 32'h22);

      // Same-edge writeback collision
      drive(1'b1, 32'h104, 5'd5, 5'd6, 1'b1, 5'd5, 32'hAB, 1'b1, acc);
      idle(1'b1);
      check("bypass pc", out_pc, 32'h104);
      check("bypass rs1", out_rs1_val, 32'hAB);
      check("bypass rs2", out_rs2_val, 32'h22);

      // x0 is always zero, even with a same-edge write and a dirty rf entry
      drive(1'b1, 32'h108, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFF, 1'b1, acc);
      idle(1'b1);
      check("x0 rs1", out_rs1_val, 32'd0);
      check("x0 rs2", out_rs2_val, 32'd0);
      drive(1'b1, 32'h10C, 5'd0, 5'd0, 1'b0, '0, '0, 1'b1, acc);
      idle(1'b1);
      check("x0 later rs1", out_rs1_val, 32'd0);
      check("x0 later pc", out_pc, 32'h10C);
      idle(1'b1);

      // Backpressure with a writeback patching the held bundle
      emit_q.delete();
      drive(1'b1, 32'h200, 5'd6, 5'd6, 1'b0, '0, '0, 1'b0, acc);
      check("stall acc1", {31'd0, acc}, 32'd1);
      drive(1'b1, 32'h204, 5'd5, 5'd6, 1'b0, '0, '0, 1'b0, acc);
      check("stall acc2", {31'd0, acc}, 32'd1);
      drive(1'b1, 32'h208, 5'd6, 5'd5, 1'b0, '0, '0, 1'b0, acc);
      check("stall full in_ready", {31'd0, acc}, 32'd0);
      drive(1'b1, 32'h208, 5'd6, 5'd5, 1'b1, 5'd6, 32'h77, 1'b0, acc);
      check("stall full in_ready 2", {31'd0, acc}, 32'd0);
      check("held pc", out_pc, 32'h200);
      check("held rs1 patched", out_rs1_val, 32'h77);
      check("held rs2 patched", out_rs2_val, 32'h77);
      n = 0;
      acc = 1'b0;
      while (!acc && n < 5) begin
         drive(1'b1, 32'h208, 5'd6, 5'd5, 1'b0, '0, '0, 1'b1, acc);
         n++;
      end
      check("stall I3 accepted", {31'd0, acc}, 32'd1);
      for (int i = 0; i < 4; i++) idle(1'b1);
      check("stall emit count", emit_q.size(), 32'd3);
      for (int i = 0; i < 3; i++)
         if (i < emit_q.size()) check("stall emit pc", emit_q[i], 32'h200 + 32'(4 * i));

      // Back-to-back stream
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 32'h300 + 32'(4 * k), 5'($urandom_range(31, 1)),
               5'($urandom_range(31, 1)), 1'b1, 5'($urandom_range(7, 1)), $urandom, 1'b1, acc);
         check("stream accept", {31'd0, acc}, 32'd1);
         if (k > 0) begin
            check("stream valid", {31'd0, out_valid}, 32'd1);
            check("stream pc", out_pc, 32'h300 + 32'(4 * (k - 1)));
         end
      end
      idle(1'b1);
      check("stream last pc", out_pc, 32'h31C);
      idle(1'b1);

      // Reset with both stages full
      drive(1'b1, 32'h400, 5'd5, 5'd6, 1'b0, '0, '0, 1'b0, acc);
      drive(1'b1, 32'h404, 5'd6, 5'd5, 1'b0, '0, '0, 1'b0, acc);
      check("pre-reset valid", {31'd0, out_valid}, 32'd1);
      rst = 1'b1;
      idle(1'b0);
      rst = 1'b0;
      check("post-reset valid", {31'd0, out_valid}, 32'd0);
      check("post-reset pc", out_pc, 32'd0);
      check("post-reset rs1", out_rs1_val, 32'd0);
      check("post-reset rs2", out_rs2_val, 32'd0);
      check("post-reset in_ready", {31'd0, in_ready}, 32'd1);
      emit_q.delete();
      for (int i = 0; i < 4; i++) idle(1'b1);
      check("dropped never emitted", emit_q.size(), 32'd0);

      // Randomized traffic with dense register hazards
      pc = 32'h1000;
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(199, 0) == 0);
         drive(($urandom_range(3, 0) != 0), pc, 5'($urandom_range(7, 0)),
               5'($urandom_range(7, 0)), $urandom_range(1, 0) == 1,
               5'($urandom_range(7, 0)), $urandom, $urandom_range(9, 0) < 7, acc);
         pc = pc + 32'd4;
      end
      rst = 1'b0;
      for (int i = 0; i < 4; i++) idle(1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
